seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter W, default 4: operand width in bits; legal range 2..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 din  input  W  operand data bus.
REQ-005 ld_a  input  1  load din into operand register A.
REQ-006 ld_b  input  1  load din into operand register B.
REQ-007 op  input  3  opcode, sampled with start: 0 CMP, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5-7 reserved.
REQ-008 start  input  1  begin operation on the current A, B and op.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse when y is valid.
REQ-011 y  output  2W  result, held until the next accepted start.
REQ-012 err  output  1  error flag for the last operation, updated with done.

Function
REQ-013 FSM states: IDLE, RUN, FIN; IDLE->FIN on start for CMP/ADD/SUB/reserved; IDLE->RUN on start for MUL/DIV; RUN->FIN after W iterations; FIN->IDLE unconditionally.
REQ-014 In IDLE, ld_a/ld_b load A/B at the edge; if both are high, both registers load din.
REQ-015 A start coinciding with a load uses the pre-edge A/B values; the load still takes effect.
REQ-016 In RUN or FIN, start, ld_a and ld_b are ignored; operands, op and y are unaffected.
REQ-017 busy is high in RUN and FIN; done is high only in FIN.
REQ-018 Latency: start at edge t -> done high in cycle t+1 for single-cycle ops and in cycle t+W+1 for MUL/DIV.
REQ-019 CMP: y = 0 if A==B, 1 if A>B, 2 if A<B (unsigned); err=0.
REQ-020 ADD: y = zero-extended A+B, carry in bit W; err=0.
REQ-021 SUB: y = A-B as a 2W-bit two's-complement value (negative results sign-extended); err=0.
REQ-022 MUL: unsigned shift-add, one partial product per RUN cycle; y = A*B exact in 2W bits; err=0.
REQ-023 DIV: restoring division, one quotient bit per RUN cycle; y = {remainder[W-1:0], quotient[W-1:0]}; err=0.
REQ-024 DIV with B==0: quotient all ones, remainder = A, err=1; latency is unchanged.
REQ-025 Reserved op: y = 0, err=1, single-cycle latency.
REQ-026 y and err change only at the edge that enters FIN, or on reset.

Reset
REQ-027 rst forces state=IDLE, A=0, B=0, y=0, err=0, busy=0, done=0; it takes priority over all inputs.
REQ-028 rst during RUN or FIN aborts the operation; no done pulse is produced for it.
REQ-029 start or load asserted in the same cycle as rst is ignored.

Configuration
REQ-030 Macro SEQ_ALU_DIV_EN, when defined, compiles in the divider and provides DIV behaviour per REQ-023/024.
REQ-031 Without SEQ_ALU_DIV_EN, no divider logic is built and op=4 is treated as reserved per REQ-025.

Verification
REQ-032 W=4, load A=9, B=3, op=1, start -> done in next cycle, y=8'h0C, err=0, busy high for exactly 1 cycle.
REQ-033 W=4, A=2, B=5, op=2 -> y=8'hFD; A=B=7, op=0 -> y=0; A=3, B=4, op=0 -> y=2.
REQ-034 W=4, A=15, B=15, op=3 -> done exactly 5 cycles after start, y=8'hE1; a start pulse mid-RUN is ignored.
REQ-035 W=4 with SEQ_ALU_DIV_EN: A=13, B=4, op=4 -> y=8'h13; B=0 -> y=8'hDF, err=1. Without the macro: op=4 -> y=0, err=1.
REQ-036 W=4, start MUL, assert rst on the 2nd RUN cycle -> y=0, busy=0, no done pulse; the next ADD after reset completes normally.

Source files
------------

// File: rtl/seq_alu_if.sv
// Operand/control/result bundle for seq_alu; the bench drives through the master
// modport and the ALU attaches through the slave modport.
interface seq_alu_if #(
  parameter int W = 4
);
  logic [W-1:0]   din;
  logic           ld_a;
  logic           ld_b;
  logic [2:0]     op;
  logic           start;
  logic           busy;
  logic           done;
  logic [2*W-1:0] y;
  logic           err;

  modport master (
    output din, ld_a, ld_b, op, start,
    input  busy, done, y, err
  );

  modport slave (
    input  din, ld_a, ld_b, op, start,
    output busy, done, y, err
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle CMP/ADD/SUB, W-cycle shift-add MUL and restoring DIV.
// Divider is built only when SEQ_ALU_DIV_EN is defined; otherwise op 4 is reserved.
module seq_alu #(
  parameter int W = 4
) (
  input logic        clk,
  input logic        rst,
  seq_alu_if.slave   bus
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  typedef enum logic [2:0] {OP_CMP, OP_ADD, OP_SUB, OP_MUL, OP_DIV} opcode_t;

  state_t         state, nextState;
  logic [W-1:0]   regA, regB;
  logic [W-1:0]   accHi, accLo;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] yReg;
  logic           errReg;
  logic           isMulti;
  logic           lastIter;

  logic [W:0]     mulSum;
  logic [W-1:0]   mulHiN, mulLoN;

`ifdef SEQ_ALU_DIV_EN
  logic           runDiv;
  logic [W:0]     divShift, divDiff;
  logic           divFits;
  logic [W-1:0]   remN, quoN;
`endif

`ifdef SEQ_ALU_DIV_EN
  assign isMulti = (bus.op == OP_MUL) || (bus.op == OP_DIV);
`else
  assign isMulti = (bus.op == OP_MUL);
`endif

  assign lastIter = (cnt == CW'(W - 1));

  // MUL: accHi holds the running partial product, accLo the unconsumed multiplier bits
  assign mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, regA} : '0);
  assign mulHiN = mulSum[W:1];
  assign mulLoN = {mulSum[0], accLo[W-1:1]};

`ifdef SEQ_ALU_DIV_EN
  // DIV: accHi is the partial remainder, accLo shifts dividend out and quotient in
  assign divShift = {accHi, accLo[W-1]};
  assign divDiff  = divShift - {1'b0, regB};
  assign divFits  = (divShift >= {1'b0, regB});
  assign remN     = divFits ? divDiff[W-1:0] : divShift[W-1:0];
  assign quoN     = {accLo[W-2:0], divFits};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) nextState = isMulti ? RUN : FIN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (lastIter) nextState = FIN;
      end
      FIN: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign bus.y   = yReg;
  assign bus.err = errReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      regA   <= '0;
      regB   <= '0;
      accHi  <= '0;
      accLo  <= '0;
      cnt    <= '0;
      yReg   <= '0;
      errReg <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      runDiv <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.ld_a) regA <= bus.din;
          if (bus.ld_b) regB <= bus.din;
          if (bus.start) begin
            cnt <= '0;
            case (bus.op)
              OP_CMP: begin
                if (regA == regB)     yReg <= '0;
                else if (regA > regB) yReg <= (2*W)'(1);
                else                  yReg <= (2*W)'(2);
                errReg <= 1'b0;
              end
              OP_ADD: begin
                yReg   <= (2*W)'(regA) + (2*W)'(regB);
                errReg <= 1'b0;
              end
              OP_SUB: begin
                yReg   <= (2*W)'(regA) - (2*W)'(regB);
                errReg <= 1'b0;
              end
              OP_MUL: begin
                accHi  <= '0;
                accLo  <= regB;
`ifdef SEQ_ALU_DIV_EN
                runDiv <= 1'b0;
`endif
              end
`ifdef SEQ_ALU_DIV_EN
              OP_DIV: begin
                accHi  <= '0;
                accLo  <= regA;
                runDiv <= 1'b1;
              end
`endif
              default: begin
                yReg   <= '0;
                errReg <= 1'b1;
              end
            endcase
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
`ifdef SEQ_ALU_DIV_EN
          if (runDiv) begin
            accHi <= remN;
            accLo <= quoN;
            if (lastIter) begin
              yReg   <= {remN, quoN};
              errReg <= (regB == '0);
            end
          end else begin
`else
          begin
`endif
            accHi <= mulHiN;
            accLo <= mulLoN;
            if (lastIter) begin
              yReg   <= {mulHiN, mulLoN};
              errReg <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at W=4; DIV expectations follow SEQ_ALU_DIV_EN.
module tb_seq_alu;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  seq_alu_if #(.W(W)) bus ();

  seq_alu #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge: inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadAB(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.din = a; bus.ld_a = 1'b1;
    tick();
    bus.ld_a = 1'b0; bus.din = b; bus.ld_b = 1'b1;
    tick();
    bus.ld_b = 1'b0;
  endtask

  task automatic runOp(input logic [2:0] o, output int lat);
    bus.op = o; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    bus.din = 4'hF; bus.ld_a = 1'b1; bus.ld_b = 1'b1; bus.op = 3'd1; bus.start = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0; bus.ld_a = 1'b0; bus.ld_b = 1'b0; bus.start = 1'b0;
    vectors++;
    if (bus.y !== 8'h00 || bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: y=%h err=%b busy=%b done=%b, want y=00 err=0 busy=0 done=0",
               bus.y, bus.err, bus.busy, bus.done);
    end
    begin
      int lat;
      runOp(3'd1, lat);
      vectors++;
      if (bus.y !== 8'h00 || lat != 1) begin
        miscompares++;
        $display("FAIL reset_ignores_load: y=%h lat=%0d, want y=00 lat=1", bus.y, lat);
      end
    end
    tick();
  endtask

  task automatic test_add();
    int lat;
    loadAB(4'd9, 4'd3);
    runOp(3'd1, lat);
    vectors++;
    if (lat != 1 || bus.y !== 8'h0C || bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL add_9_3: lat=%0d y=%h err=%b busy=%b, want lat=1 y=0c err=0 busy=1",
               lat, bus.y, bus.err, bus.busy);
    end
    tick();
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.y !== 8'h0C) begin
      miscompares++;
      $display("FAIL add_after: busy=%b done=%b y=%h, want busy=0 done=0 y=0c",
               bus.busy, bus.done, bus.y);
    end
    loadAB(4'd15, 4'd15);
    runOp(3'd1, lat);
    vectors++;
    if (bus.y !== 8'h1E || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL add_carry: y=%h err=%b, want y=1e err=0", bus.y, bus.err);
    end
    tick();
  endtask

  task automatic test_sub_cmp();
    int lat;
    loadAB(4'd2, 4'd5);
    runOp(3'd2, lat);
    vectors++;
    if (lat != 1 || bus.y !== 8'hFD || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_2_5: lat=%0d y=%h err=%b, want lat=1 y=fd err=0", lat, bus.y, bus.err);
    end
    tick();
    loadAB(4'd7, 4'd7);
    runOp(3'd0, lat);
    vectors++;
    if (bus.y !== 8'h00 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL cmp_eq: y=%h err=%b, want y=00 err=0", bus.y, bus.err);
    end
    tick();
    loadAB(4'd3, 4'd4);
    runOp(3'd0, lat);
    vectors++;
    if (bus.y !== 8'h02) begin
      miscompares++;
      $display("FAIL cmp_lt: y=%h, want 02", bus.y);
    end
    tick();
    loadAB(4'd12, 4'd4);
    runOp(3'd0, lat);
    vectors++;
    if (bus.y !== 8'h01) begin
      miscompares++;
      $display("FAIL cmp_gt: y=%h, want 01", bus.y);
    end
    tick();
  endtask

  task automatic test_mul();
    int lat;
    loadAB(4'd15, 4'd15);
    bus.op = 3'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_run_flags: busy=%b done=%b, want busy=1 done=0", bus.busy, bus.done);
    end
    tick();
    bus.start = 1'b1; bus.op = 3'd1; bus.ld_a = 1'b1; bus.din = 4'd0;
    tick();
    bus.start = 1'b0; bus.ld_a = 1'b0; bus.op = 3'd3;
    lat = 3;
    while (bus.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    vectors++;
    if (lat != 5 || bus.y !== 8'hE1 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_15_15: lat=%0d y=%h err=%b, want lat=5 y=e1 err=0", lat, bus.y, bus.err);
    end
    tick();
    runOp(3'd1, lat);
    vectors++;
    if (bus.y !== 8'h1E) begin
      miscompares++;
      $display("FAIL mul_ignored_load: y=%h, want 1e", bus.y);
    end
    tick();
    loadAB(4'd6, 4'd11);
    runOp(3'd3, lat);
    vectors++;
    if (lat != 5 || bus.y !== 8'h42) begin
      miscompares++;
      $display("FAIL mul_6_11: lat=%0d y=%h, want lat=5 y=42", lat, bus.y);
    end
    tick();
  endtask

  task automatic test_div();
    int lat;
    loadAB(4'd13, 4'd4);
    runOp(3'd4, lat);
`ifdef SEQ_ALU_DIV_EN
    vectors++;
    if (lat != 5 || bus.y !== 8'h13 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL div_13_4: lat=%0d y=%h err=%b, want lat=5 y=13 err=0", lat, bus.y, bus.err);
    end
    tick();
    loadAB(4'd13, 4'd0);
    runOp(3'd4, lat);
    vectors++;
    if (lat != 5 || bus.y !== 8'hDF || bus.err !== 1'b1) begin
      miscompares++;
      $display("FAIL div_by_zero: lat=%0d y=%h err=%b, want lat=5 y=df err=1", lat, bus.y, bus.err);
    end
`else
    vectors++;
    if (lat != 1 || bus.y !== 8'h00 || bus.err !== 1'b1) begin
      miscompares++;
      $display("FAIL div_disabled: lat=%0d y=%h err=%b, want lat=1 y=00 err=1", lat, bus.y, bus.err);
    end
`endif
    tick();
    loadAB(4'd5, 4'd5);
    runOp(3'd7, lat);
    vectors++;
    if (lat != 1 || bus.y !== 8'h00 || bus.err !== 1'b1) begin
      miscompares++;
      $display("FAIL reserved_op7: lat=%0d y=%h err=%b, want lat=1 y=00 err=1", lat, bus.y, bus.err);
    end
    tick();
    runOp(3'd1, lat);
    vectors++;
    if (bus.y !== 8'h0A || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clears: y=%h err=%b, want y=0a err=0", bus.y, bus.err);
    end
    tick();
  endtask

  task automatic test_load_with_start();
    int lat;
    loadAB(4'd5, 4'd2);
    bus.din = 4'd1; bus.ld_a = 1'b1;
    runOp(3'd1, lat);
    bus.ld_a = 1'b0;
    vectors++;
    if (bus.y !== 8'h07) begin
      miscompares++;
      $display("FAIL start_uses_old_a: y=%h, want 07", bus.y);
    end
    tick();
    runOp(3'd1, lat);
    vectors++;
    if (bus.y !== 8'h03) begin
      miscompares++;
      $display("FAIL load_took_effect: y=%h, want 03", bus.y);
    end
    tick();
  endtask

  task automatic test_abort();
    int lat;
    int doneSeen = 0;
    loadAB(4'd15, 4'd15);
    bus.op = 3'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.y !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_state: y=%h busy=%b done=%b, want y=00 busy=0 done=0",
               bus.y, bus.busy, bus.done);
    end
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1) doneSeen++;
      tick();
    end
    vectors++;
    if (doneSeen != 0) begin
      miscompares++;
      $display("FAIL abort_no_done: done pulses=%0d, want 0", doneSeen);
    end
    loadAB(4'd9, 4'd3);
    runOp(3'd1, lat);
    vectors++;
    if (lat != 1 || bus.y !== 8'h0C || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL add_after_abort: lat=%0d y=%h err=%b, want lat=1 y=0c err=0", lat, bus.y, bus.err);
    end
    tick();
  endtask

  initial begin
    bus.din = '0; bus.ld_a = 1'b0; bus.ld_b = 1'b0; bus.op = '0; bus.start = 1'b0;
    test_reset();
    test_add();
    test_sub_cmp();
    test_mul();
    test_div();
    test_load_with_start();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
